// File: rtl/traffic_phase_controller_pkg.sv
// Shared phase encoding, light codes and duration helpers for traffic_phase_controller.
// The WALK phase only exists when PED_WALK_EN is defined.
package tlc_pkg;

    typedef enum logic [2:0] {
        INIT_RED,
        NS_GREEN,
        NS_YELLOW,
        RED_A,
        EW_GREEN,
        EW_YELLOW,
        RED_B
`ifdef PED_WALK_EN
        , WALK
`endif
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Clearance phases (and anything unlisted) fall back to the all-red duration.
    function automatic int phase_duration(input phase_t p, input int t_green,
                                          input int t_yellow, input int t_allred);
        case (p)
            NS_GREEN, EW_GREEN:   return t_green;
            NS_YELLOW, EW_YELLOW: return t_yellow;
            default:              return t_allred;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_controller.sv
// Traffic-light phase sequencer that loads an external down-counter timer per phase.
// Define PED_WALK_EN to add the latched pedestrian WALK phase after the all-red clearances.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 8,
    parameter int TW       = $clog2(max4(T_GREEN, T_YELLOW, T_ALLRED, T_WALK)) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          timer_done,
    input  logic          ped_req,
    output logic          timer_load,
    output logic [TW-1:0] timer_value,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          ped_walk
);

    phase_t        state_q, state_d;
    logic          started_q, started_d;
    logic          timer_load_q, timer_load_d;
    logic [TW-1:0] timer_value_q, timer_value_d;
    logic          advance;

`ifdef PED_WALK_EN
    logic ped_pending_q, ped_pending_d;
    logic walk_to_ew_q, walk_to_ew_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // A done pulse only counts once the current phase's load has been issued and retired.
    assign advance = started_q && !timer_load_q && timer_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= INIT_RED;
            started_q     <= 1'b0;
            timer_load_q  <= 1'b0;
            timer_value_q <= '0;
`ifdef PED_WALK_EN
            ped_pending_q <= 1'b0;
            walk_to_ew_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            started_q     <= started_d;
            timer_load_q  <= timer_load_d;
            timer_value_q <= timer_value_d;
`ifdef PED_WALK_EN
            ped_pending_q <= ped_pending_d;
            walk_to_ew_q  <= walk_to_ew_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        started_d     = 1'b1;
        timer_load_d  = 1'b0;
        timer_value_d = timer_value_q;
`ifdef PED_WALK_EN
        ped_pending_d = ped_pending_q;
        walk_to_ew_d  = walk_to_ew_q;
`endif

        if (!started_q) begin
            timer_load_d  = 1'b1;
            timer_value_d = TW'(phase_duration(state_q, T_GREEN, T_YELLOW, T_ALLRED));
        end else if (advance) begin
            case (state_q)
                INIT_RED:  state_d = NS_GREEN;
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = RED_A;
                RED_A:     state_d = EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = RED_B;
                RED_B:     state_d = NS_GREEN;
`ifdef PED_WALK_EN
                WALK:      state_d = walk_to_ew_q ? EW_GREEN : NS_GREEN;
`endif
                default:   state_d = INIT_RED;
            endcase
`ifdef PED_WALK_EN
            if ((state_q == RED_A || state_q == RED_B) && ped_pending_q) begin
                walk_to_ew_d  = (state_q == RED_A);
                state_d       = WALK;
                ped_pending_d = 1'b0;
            end
`endif
            timer_load_d  = 1'b1;
            timer_value_d = TW'(phase_duration(state_d, T_GREEN, T_YELLOW, T_ALLRED));
`ifdef PED_WALK_EN
            if (state_d == WALK) timer_value_d = TW'(T_WALK);
`endif
        end

`ifdef PED_WALK_EN
        // Placed last so a request arriving on the WALK entry edge is kept for the next clearance.
        if (ped_req) ped_pending_d = 1'b1;
`endif
    end

    assign timer_load  = timer_load_q;
    assign timer_value = timer_value_q;

    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        case (state_q)
            NS_GREEN:  ns_light = LIGHT_GREEN;
            NS_YELLOW: ns_light = LIGHT_YELLOW;
            EW_GREEN:  ew_light = LIGHT_GREEN;
            EW_YELLOW: ew_light = LIGHT_YELLOW;
            default: begin
                ns_light = LIGHT_RED;
                ew_light = LIGHT_RED;
            end
        endcase
    end

`ifdef PED_WALK_EN
    assign ped_walk = (state_q == WALK);
`else
    assign ped_walk = 1'b0;
`endif

endmodule
